// File: rtl/hazard_detection_unit_pkg.sv
// Shared defaults and FSM state type for the load-use hazard detection unit.
package hazard_detection_unit_pkg;

    localparam int NUM_REGS_DEF        = 32;
    localparam int REG_ADDR_W_DEF      = 5;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hdu_state_t;

endpackage

// File: rtl/hazard_detection_unit_scoreboard.sv
// Per-register "load in flight" bit array plus a count of loads outstanding.
module hazard_scoreboard
    import hazard_detection_unit_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   set_en,
    input  logic [REG_ADDR_W-1:0]                  set_addr,
    input  logic                                   clr_en,
    input  logic [REG_ADDR_W-1:0]                  clr_addr,
    input  logic                                   inc,
    input  logic                                   dec,
    output logic [NUM_REGS-1:0]                    busy,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   count
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    // Set is applied after clear so a same-register issue/response leaves the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            count <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != '0)) begin
                busy[set_addr] <= 1'b1;
            end
            case ({inc, dec})
                2'b10:   count <= count + OUT_W'(1);
                2'b01:   count <= count - OUT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection: RAW/WAW/structural stalls, branch flush, stall FSM and counters.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   id_valid,
    input  logic [REG_ADDR_W-1:0]                  id_rs1,
    input  logic [REG_ADDR_W-1:0]                  id_rs2,
    input  logic                                   id_rs1_used,
    input  logic                                   id_rs2_used,
    input  logic                                   id_is_load,
    input  logic [REG_ADDR_W-1:0]                  id_rd,
    input  logic                                   ld_resp_valid,
    input  logic [REG_ADDR_W-1:0]                  ld_resp_rd,
    input  logic                                   branch_taken,
    output logic                                   stall_fetch,
    output logic                                   stall_decode,
    output logic                                   bubble_ex,
    output logic                                   flush_decode,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic [CNT_W-1:0]                       stall_cycles,
    output logic                                   sb_error
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    hdu_state_t          state;
    logic [NUM_REGS-1:0] sb_busy;
    logic                resp_hit;
    logic                resp_drain;
    logic                resp_ok;
    logic                resp_err;
    logic                raw_rs1;
    logic                raw_rs2;
    logic                waw;
    logic                full;
    logic                stall;
    logic                flush;
    logic                issue;
    logic                fsm_in_stall_unused;

    hazard_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .REG_ADDR_W      (REG_ADDR_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue),
        .set_addr (id_rd),
        .clr_en   (resp_hit),
        .clr_addr (ld_resp_rd),
        .inc      (issue),
        .dec      (resp_ok),
        .busy     (sb_busy),
        .count    (outstanding)
    );

    // A response for x0 only retires a slot; any response that matches nothing is an error.
    assign resp_hit   = ld_resp_valid && (ld_resp_rd != '0) && sb_busy[ld_resp_rd];
    assign resp_drain = ld_resp_valid && (ld_resp_rd == '0) && (outstanding != '0);
    assign resp_ok    = resp_hit || resp_drain;
    assign resp_err   = ld_resp_valid && !resp_ok;

    assign raw_rs1 = id_rs1_used && (id_rs1 != '0) && sb_busy[id_rs1]
                     && !(ld_resp_valid && (ld_resp_rd == id_rs1));
    assign raw_rs2 = id_rs2_used && (id_rs2 != '0) && sb_busy[id_rs2]
                     && !(ld_resp_valid && (ld_resp_rd == id_rs2));
    assign waw     = id_is_load && (id_rd != '0) && sb_busy[id_rd]
                     && !(resp_hit && (ld_resp_rd == id_rd));
    // Only a response that actually retires a load frees a slot for the new one.
    assign full    = id_is_load && (outstanding == OUT_W'(MAX_OUTSTANDING)) && !resp_ok;

    assign stall = rst_n && !branch_taken && id_valid && (raw_rs1 || raw_rs2 || waw || full);
    assign flush = rst_n && branch_taken;
    assign issue = rst_n && id_valid && id_is_load && !stall && !branch_taken;

    assign stall_fetch  = stall;
    assign stall_decode = stall;
    assign bubble_ex    = stall || flush;
    assign flush_decode = flush;

    assign fsm_in_stall_unused = (state == ST_STALL);

    // Stall FSM, saturating stall counter and sticky scoreboard error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            stall_cycles <= '0;
            sb_error     <= 1'b0;
        end else begin
            if (branch_taken) begin
                state <= ST_RUN;
            end else if (stall) begin
                state <= ST_STALL;
            end else begin
                state <= ST_RUN;
            end
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (resp_err) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed scoreboard bench for hazard_detection_unit with default parameters.
module tb_hazard_detection_unit;
    import hazard_detection_unit_pkg::*;

    typedef struct {
        string       tag;
        int unsigned val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        id_is_load;
    logic [4:0]  id_rd;
    logic        ld_resp_valid;
    logic [4:0]  ld_resp_rd;
    logic        branch_taken;
    logic        stall_fetch;
    logic        stall_decode;
    logic        bubble_ex;
    logic        flush_decode;
    logic [2:0]  outstanding;
    logic [15:0] stall_cycles;
    logic        sb_error;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    hazard_detection_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_is_load    (id_is_load),
        .id_rd         (id_rd),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_rd    (ld_resp_rd),
        .branch_taken  (branch_taken),
        .stall_fetch   (stall_fetch),
        .stall_decode  (stall_decode),
        .bubble_ex     (bubble_ex),
        .flush_decode  (flush_decode),
        .outstanding   (outstanding),
        .stall_cycles  (stall_cycles),
        .sb_error      (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2, input logic ld,
                                  input logic [4:0] rd, input logic rv, input logic [4:0] rrd,
                                  input logic br);
        @(negedge clk);
        id_valid      = v;
        id_rs1        = rs1;
        id_rs1_used   = u1;
        id_rs2        = rs2;
        id_rs2_used   = u2;
        id_is_load    = ld;
        id_rd         = rd;
        ld_resp_valid = rv;
        ld_resp_rd    = rrd;
        branch_taken  = br;
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_out(input string tag, input int unsigned val);
        exp_q.push_back('{tag, val});
    endtask

    task automatic expect_ctl(input int unsigned stall, input int unsigned bubble,
                              input int unsigned flush, input int unsigned outs);
        expect_out("stall_fetch", stall);
        expect_out("stall_decode", stall);
        expect_out("bubble_ex", bubble);
        expect_out("flush_decode", flush);
        expect_out("outstanding", outs);
    endtask

    function automatic int unsigned observe(input string tag);
        case (tag)
            "stall_fetch":  observe = 32'(stall_fetch);
            "stall_decode": observe = 32'(stall_decode);
            "bubble_ex":    observe = 32'(bubble_ex);
            "flush_decode": observe = 32'(flush_decode);
            "outstanding":  observe = 32'(outstanding);
            "stall_cycles": observe = 32'(stall_cycles);
            "sb_error":     observe = 32'(sb_error);
            "fsm_stall":    observe = 32'(dut.state == ST_STALL);
            default:        observe = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Pops every pending expectation and compares it to the live DUT output.
    task automatic check_output();
        exp_t        e;
        int unsigned obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.tag);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        id_valid      = 1'b0;
        id_rs1        = '0;
        id_rs2        = '0;
        id_rs1_used   = 1'b0;
        id_rs2_used   = 1'b0;
        id_is_load    = 1'b0;
        id_rd         = '0;
        ld_resp_valid = 1'b0;
        ld_resp_rd    = '0;
        branch_taken  = 1'b1;

        // Reset: outputs forced low even with a branch request pending
        repeat (2) @(negedge clk);
        expect_ctl(0, 0, 0, 0);
        expect_out("stall_cycles", 0);
        expect_out("sb_error", 0);
        expect_out("fsm_stall", 0);
        check_output();
        idle();
        rst_n = 1'b1;

        $display("[TB] load-use RAW on x5");
        apply_stimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        expect_ctl(0, 0, 0, 0); check_output();
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_ctl(1, 1, 0, 1); expect_out("stall_cycles", 0); check_output();
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_ctl(1, 1, 0, 1); expect_out("stall_cycles", 1); expect_out("fsm_stall", 1); check_output();
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
        expect_ctl(0, 0, 0, 1); expect_out("stall_cycles", 2); check_output();
        idle();
        expect_ctl(0, 0, 0, 0); expect_out("stall_cycles", 2); expect_out("fsm_stall", 0);
        expect_out("sb_error", 0); check_output();

        $display("[TB] structural limit");
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1, 0, 0, 0, 0, 1, 5'(i), 0, 0, 0);
            expect_ctl(0, 0, 0, 32'(i - 1)); check_output();
        end
        apply_stimulus(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        expect_ctl(1, 1, 0, 4); check_output();
        apply_stimulus(1, 0, 0, 0, 0, 1, 6, 1, 1, 0);
        expect_ctl(0, 0, 0, 4); check_output();
        idle();
        expect_ctl(0, 0, 0, 4); expect_out("stall_cycles", 3); check_output();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, 0); expect_out("outstanding", 4); check_output();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0); expect_out("outstanding", 3); check_output();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, 0); expect_out("outstanding", 2); check_output();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 0); expect_out("outstanding", 1); check_output();
        idle();
        expect_out("outstanding", 0); expect_out("sb_error", 0); check_output();

        $display("[TB] WAW and same-register issue/response");
        apply_stimulus(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        expect_ctl(0, 0, 0, 0); check_output();
        apply_stimulus(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        expect_ctl(1, 1, 0, 1); check_output();
        apply_stimulus(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        expect_ctl(0, 0, 0, 1); check_output();
        apply_stimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_ctl(1, 1, 0, 1); expect_out("stall_cycles", 4); check_output();
        apply_stimulus(1, 0, 0, 9, 1, 0, 0, 1, 9, 0);
        expect_ctl(0, 0, 0, 1); check_output();
        idle();
        expect_ctl(0, 0, 0, 0); expect_out("stall_cycles", 5); expect_out("sb_error", 0); check_output();

        $display("[TB] load to x0");
        apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        expect_ctl(0, 0, 0, 0); check_output();
        apply_stimulus(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_ctl(0, 0, 0, 1); check_output();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_ctl(0, 0, 0, 1); check_output();
        idle();
        expect_ctl(0, 0, 0, 0); expect_out("sb_error", 0); check_output();

        $display("[TB] branch overrides stall");
        apply_stimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        expect_ctl(0, 0, 0, 0); check_output();
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_ctl(1, 1, 0, 1); check_output();
        apply_stimulus(1, 5, 1, 0, 0, 1, 10, 0, 0, 1);
        expect_ctl(0, 1, 1, 1); expect_out("fsm_stall", 1); check_output();
        idle();
        expect_ctl(0, 0, 0, 1); expect_out("fsm_stall", 0); expect_out("stall_cycles", 6); check_output();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        expect_out("outstanding", 1); check_output();
        idle();
        expect_out("outstanding", 0); expect_out("sb_error", 0); check_output();

        $display("[TB] orphan response");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        expect_out("sb_error", 0); check_output();
        idle();
        expect_out("sb_error", 1); expect_out("outstanding", 0); check_output();
        idle();
        expect_out("sb_error", 1); expect_out("outstanding", 0); check_output();

        $display("[TB] counter saturation and reset mid-stall");
        apply_stimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        expect_ctl(0, 0, 0, 0); check_output();
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_ctl(1, 1, 0, 1); expect_out("stall_cycles", 6); check_output();
        repeat (70000) @(negedge clk);
        expect_ctl(1, 1, 0, 1); expect_out("stall_cycles", 65535); check_output();
        rst_n = 1'b0;
        expect_ctl(0, 0, 0, 0); expect_out("stall_cycles", 0); expect_out("sb_error", 0);
        expect_out("fsm_stall", 0); check_output();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_ctl(0, 0, 0, 0); expect_out("stall_cycles", 0); check_output();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
